// File: rtl/clk_freq_monitor.sv
// clk_freq_monitor: checks the ADC-test PLL output frequency from the 50 MHz reference domain.
// It counts synchronised rising edges of mon_clk over fixed windows and asserts freq_ok after
// LOCK_WINDOWS consecutive in-tolerance windows.
// Optional build macro CLK_FREQ_MONITOR_STICKY_ERR_EN adds err_clr / err_sticky; a sticky error
// holds freq_ok low.
module clk_freq_monitor #(
    parameter int unsigned WINDOW_CYCLES  = 3072,
    parameter int unsigned EXPECTED_EDGES = 72,
    parameter int unsigned TOL            = 1,
    parameter int unsigned LOCK_WINDOWS   = 4,
    parameter int unsigned CNT_W          = 12,
    parameter int unsigned ERR_W          = 8
) (
    input  logic             refclk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             pll_locked,
    input  logic             mon_clk,
`ifdef CLK_FREQ_MONITOR_STICKY_ERR_EN
    input  logic             err_clr,
    output logic             err_sticky,
`endif
    output logic             freq_ok,
    output logic [CNT_W-1:0] meas_count,
    output logic             meas_valid,
    output logic             freq_err,
    output logic [ERR_W-1:0] err_count
);

    localparam int unsigned WIN_W    = $clog2(WINDOW_CYCLES);
    localparam int unsigned GOOD_W   = $clog2(LOCK_WINDOWS + 1);
    localparam int unsigned LO_BOUND = (EXPECTED_EDGES > TOL) ? (EXPECTED_EDGES - TOL) : 0;
    localparam int unsigned HI_BOUND = EXPECTED_EDGES + TOL;
    localparam logic [CNT_W-1:0] CNT_SAT = '1;
    localparam logic [ERR_W-1:0] ERR_SAT = '1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    state_t              state, state_d;
    logic [GOOD_W-1:0]   good_cnt, good_cnt_d;
    logic [WIN_W-1:0]    win_cnt;
    logic [CNT_W-1:0]    edge_cnt, edge_sum;
    logic                lock_s1, lock_s2;
    logic                mon_s1, mon_s2, mon_s3;
    logic                mon_edge, active, terminal, eval, window_good;
    logic                freq_ok_d, freq_err_d, sticky_d;

    assign mon_edge    = mon_s2 & ~mon_s3;
    assign active      = en & lock_s2;
    assign terminal    = (state != IDLE) && (win_cnt == WIN_W'(WINDOW_CYCLES - 1));
    assign eval        = active & terminal;
    assign edge_sum    = (edge_cnt == CNT_SAT) ? CNT_SAT : (edge_cnt + CNT_W'(mon_edge));
    assign window_good = (edge_sum != CNT_SAT) && (edge_sum >= CNT_W'(LO_BOUND))
                         && (edge_sum <= CNT_W'(HI_BOUND));

    // Two-flop synchronisers for pll_locked and mon_clk, plus edge-detect delay flop
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            lock_s1 <= 1'b0;
            lock_s2 <= 1'b0;
            mon_s1  <= 1'b0;
            mon_s2  <= 1'b0;
            mon_s3  <= 1'b0;
        end else begin
            lock_s1 <= pll_locked;
            lock_s2 <= lock_s1;
            mon_s1  <= mon_clk;
            mon_s2  <= mon_s1;
            mon_s3  <= mon_s2;
        end
    end

    // Next-state and registered-output decode; loss of enable/lock overrides everything
    always_comb begin
        state_d    = state;
        good_cnt_d = good_cnt;
        freq_err_d = 1'b0;
        case (state)
            IDLE: begin
                if (active) state_d = ACQUIRE;
            end
            ACQUIRE: begin
                if (eval) begin
                    if (window_good) begin
                        good_cnt_d = good_cnt + GOOD_W'(1);
                        if (good_cnt == GOOD_W'(LOCK_WINDOWS - 1)) state_d = LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end
            end
            LOCKED: begin
                if (eval && !window_good) begin
                    freq_err_d = 1'b1;
                    good_cnt_d = '0;
                    state_d    = ACQUIRE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (!active) begin
            state_d    = IDLE;
            good_cnt_d = '0;
            freq_err_d = 1'b0;
        end
`ifdef CLK_FREQ_MONITOR_STICKY_ERR_EN
        sticky_d  = freq_err_d | (err_sticky & ~err_clr);
`else
        sticky_d  = 1'b0;
`endif
        freq_ok_d = (state_d == LOCKED) & ~sticky_d;
    end

    // FSM state register
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_d;
            good_cnt <= good_cnt_d;
        end
    end

    // Window and edge counters; a completed window publishes its count for one cycle
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            meas_count <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            if ((state == IDLE) || !active) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else if (terminal) begin
                win_cnt    <= '0;
                edge_cnt   <= '0;
                meas_count <= edge_sum;
                meas_valid <= 1'b1;
            end else begin
                win_cnt  <= win_cnt + WIN_W'(1);
                edge_cnt <= edge_sum;
            end
        end
    end

    // Status outputs and saturating error counter
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            freq_ok   <= 1'b0;
            freq_err  <= 1'b0;
            err_count <= '0;
        end else begin
            freq_ok  <= freq_ok_d;
            freq_err <= freq_err_d;
            if (freq_err_d && (err_count != ERR_SAT)) err_count <= err_count + ERR_W'(1);
        end
    end

`ifdef CLK_FREQ_MONITOR_STICKY_ERR_EN
    // Sticky error flag: set dominates clear
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) err_sticky <= 1'b0;
        else        err_sticky <= sticky_d;
    end
`endif

endmodule
